// File: rtl/pwm_cap_pkg.sv
// Shared definitions for the PWM capture block: FSM states, counter limit and result record.
package pwm_cap_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        HIGH,
        LOW
    } cap_state_e;

    // Widest counter the result record can carry; pwm_capture requires CNT_W <= RES_W_MAX.
    localparam int RES_W_MAX = 32;

    typedef struct packed {
        logic [RES_W_MAX-1:0] period;
        logic [RES_W_MAX-1:0] high_time;
    } result_t;

    function automatic logic [RES_W_MAX-1:0] cnt_max(input int w);
        return RES_W_MAX'((64'd1 << w) - 64'd1);
    endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// Result channel of pwm_capture: period/high_time payload with a valid/ready handshake.
interface pwm_capture_if #(
    parameter int CNT_W = 28
) ();

    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             meas_valid;
    logic             meas_ready;

    modport master (
        output period,
        output high_time,
        output meas_valid,
        input  meas_ready
    );

    modport slave (
        input  period,
        input  high_time,
        input  meas_valid,
        output meas_ready
    );

endinterface

// File: rtl/pwm_in_sync.sv
// Synchroniser, optional glitch filter (PWM_CAP_FILTER_EN) and registered edge detect for pwm_i.
module pwm_in_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_i};
        end
    end

`ifdef PWM_CAP_FILTER_EN
    localparam int FCW = $clog2(FILTER_LEN + 1);

    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic           filt_q, filt_d;

    // A new level must be seen on FILTER_LEN consecutive samples; any return to the old level restarts.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (sync_q[SYNC_STAGES-1] != filt_q) begin
            if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
                filt_d = sync_q[SYNC_STAGES-1];
            end else begin
                fcnt_d = fcnt_q + FCW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign lvl = filt_q;
`else
    localparam int filter_len_unused = FILTER_LEN;

    assign lvl = sync_q[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            prev_q <= lvl;
            rise_q <= lvl & ~prev_q;
            fall_q <= ~lvl & prev_q;
        end
    end

    // prev_q is the level the current edge pulses refer to.
    assign level_o = prev_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time capture with valid/ready result channel and sticky overrun/timeout flags.
// Build option: define PWM_CAP_FILTER_EN to enable the input glitch filter in pwm_in_sync.
module pwm_capture
    import pwm_cap_pkg::*;
#(
    parameter int CNT_W       = 28,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pwm_in,
    input  logic          enable,
    pwm_capture_if.master meas,
    output logic          overrun,
    output logic          timeout
);

    localparam logic [RES_W_MAX-1:0] CntMaxW = cnt_max(CNT_W);
    localparam logic [CNT_W-1:0]     CntMax  = CntMaxW[CNT_W-1:0];

    logic [1:0]       rst_sync_q;
    logic             rst_int;

    logic             level_unused;
    logic             rise;
    logic             fall;

    cap_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic             done;
    logic             sat;

    logic             en_q;
    logic             en_rise;
    logic             hs;
    result_t          res_q, res_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;

    // Reset asserts asynchronously but is released two clocks after rst drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_sync_q <= 2'b11;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b0};
        end
    end

    assign rst_int = rst_sync_q[1];

    pwm_in_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_sync (
        .clk     (clk),
        .rst     (rst_int),
        .pwm_i   (pwm_in),
        .level_o (level_unused),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        done    = 1'b0;
        sat     = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: state_d = ARM;
                ARM: begin
                    if (rise) begin
                        state_d = HIGH;
                        cnt_d   = CNT_W'(1);
                    end
                end
                HIGH, LOW: begin
                    if (cnt_q == CntMax) begin
                        state_d = ARM;
                        cnt_d   = '0;
                        sat     = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (state_q == HIGH && fall) begin
                            state_d = LOW;
                            hi_d    = cnt_q;
                        end
                        // Closing rise also opens the next period, so consecutive periods are all measured.
                        if (state_q == LOW && rise) begin
                            state_d = HIGH;
                            cnt_d   = CNT_W'(1);
                            done    = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign en_rise = enable & ~en_q;
    assign hs      = valid_q & meas.meas_ready;

    always_comb begin
        res_d     = res_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        timeout_d = timeout_q;
        if (hs) begin
            valid_d = 1'b0;
            res_d   = '0;
        end
        if (done) begin
            if (!valid_q || meas.meas_ready) begin
                valid_d         = 1'b1;
                res_d.period    = RES_W_MAX'(cnt_q);
                res_d.high_time = RES_W_MAX'(hi_q);
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (sat) begin
            timeout_d = 1'b1;
        end
        if (en_rise) begin
            overrun_d = 1'b0;
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            en_q      <= 1'b0;
            res_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            en_q      <= enable;
            res_q     <= res_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
        end
    end

    assign meas.period     = res_q.period[CNT_W-1:0];
    assign meas.high_time  = res_q.high_time[CNT_W-1:0];
    assign meas.meas_valid = valid_q;
    assign overrun         = overrun_q;
    assign timeout         = timeout_q;

    generate
        if (CNT_W < RES_W_MAX) begin : g_res_pad
            logic res_pad_unused;
            assign res_pad_unused = |{res_q.period[RES_W_MAX-1:CNT_W],
                                      res_q.high_time[RES_W_MAX-1:CNT_W]};
        end
    endgenerate

endmodule

// File: tb/tb_pwm_capture.sv
// Directed, table-driven bench for pwm_capture (CNT_W=8 so the timeout path is reachable).
module tb_pwm_capture;

    localparam int CNT_W = 8;
`ifdef PWM_CAP_FILTER_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pwm_in = 1'b0;
    logic enable = 1'b0;
    logic overrun;
    logic timeout;

    pwm_capture_if #(.CNT_W(CNT_W)) meas ();

    pwm_capture #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (2),
        .FILTER_LEN  (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pwm_in  (pwm_in),
        .enable  (enable),
        .meas    (meas),
        .overrun (overrun),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int per;
        int hi;
    } res_t;

    typedef struct {
        int hi;
        int lo;
        int reps;
        int exp_per;
        int exp_hi;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    res_t got[$];
    vec_t vecs[$];
    res_t exp_q[$];

    initial begin
        meas.meas_ready = 1'b1;
        forever begin
            @(negedge clk);
            #2;
            if (meas.meas_valid && meas.meas_ready) begin
                res_t r;
                r.per = int'(meas.period);
                r.hi  = int'(meas.high_time);
                got.push_back(r);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pwm_period(input int hi, input int lo);
        pwm_in = 1'b1;
        tick(hi);
        pwm_in = 1'b0;
        tick(lo);
    endtask

    task automatic restart();
        pwm_in = 1'b0;
        enable = 1'b0;
        tick(LAT + 4);
        enable = 1'b1;
        tick(2);
        got.delete();
    endtask

    initial begin
`ifdef PWM_CAP_FILTER_EN
        vecs.push_back('{4, 4, 4, 8, 4});
        vecs.push_back('{5, 7, 3, 12, 5});
        vecs.push_back('{8, 12, 2, 20, 8});
        exp_q.push_back('{20, 10});
        exp_q.push_back('{20, 10});
        exp_q.push_back('{20, 10});
`else
        vecs.push_back('{3, 5, 4, 8, 3});
        vecs.push_back('{4, 6, 3, 10, 4});
        vecs.push_back('{1, 1, 4, 2, 1});
        vecs.push_back('{7, 1, 3, 8, 7});
        vecs.push_back('{10, 20, 2, 30, 10});
        exp_q.push_back('{20, 10});
        exp_q.push_back('{6, 4});
        exp_q.push_back('{14, 4});
        exp_q.push_back('{20, 10});
`endif

        // Reset state
        tick(3);
        check("rst valid", int'(meas.meas_valid), 0);
        check("rst period", int'(meas.period), 0);
        check("rst high_time", int'(meas.high_time), 0);
        check("rst overrun", int'(overrun), 0);
        check("rst timeout", int'(timeout), 0);
        rst = 1'b0;
        tick(3);

        // Table of steady waveforms, consumer always ready
        foreach (vecs[v]) begin
            restart();
            for (int r = 0; r < vecs[v].reps; r++) pwm_period(vecs[v].hi, vecs[v].lo);
            pwm_in = 1'b1;
            tick(LAT + 4);
            check($sformatf("vec%0d count", v), got.size(), vecs[v].reps);
            for (int k = 0; k < got.size() && k < vecs[v].reps; k++) begin
                check($sformatf("vec%0d[%0d] period", v, k), got[k].per, vecs[v].exp_per);
                check($sformatf("vec%0d[%0d] high_time", v, k), got[k].hi, vecs[v].exp_hi);
            end
            check($sformatf("vec%0d overrun", v), int'(overrun), 0);
        end

        // Back-pressure: hold first result, drop second, then release
        meas.meas_ready = 1'b0;
        restart();
        pwm_period(4, 4);
        pwm_in = 1'b1;
        tick(LAT + 2);
        check("hold valid", int'(meas.meas_valid), 1);
        check("hold period", int'(meas.period), 8);
        check("hold high_time", int'(meas.high_time), 4);
        check("hold overrun pre", int'(overrun), 0);
        pwm_in = 1'b0;
        tick(5);
        pwm_in = 1'b1;
        tick(LAT + 2);
        check("drop valid", int'(meas.meas_valid), 1);
        check("drop period", int'(meas.period), 8);
        check("drop high_time", int'(meas.high_time), 4);
        check("drop overrun", int'(overrun), 1);
        meas.meas_ready = 1'b1;
        tick(1);
        check("release valid", int'(meas.meas_valid), 0);
        meas.meas_ready = 1'b0;

        // Completion coinciding with the handshake keeps valid high with the new result
        pwm_in = 1'b0;
        tick(4);
        pwm_in = 1'b1;
        tick(4);
        pwm_in = 1'b0;
        tick(4);
        check("coin held valid", int'(meas.meas_valid), 1);
        check("coin held period", int'(meas.period), LAT + 7);
        check("coin held high_time", int'(meas.high_time), LAT + 3);
        pwm_in = 1'b1;
        tick(LAT);
        meas.meas_ready = 1'b1;
        tick(1);
        check("coin valid", int'(meas.meas_valid), 1);
        check("coin period", int'(meas.period), 8);
        check("coin high_time", int'(meas.high_time), 4);
        tick(1);
        check("coin after valid", int'(meas.meas_valid), 0);

        // Stuck-high input saturates the counter
        restart();
        check("to overrun cleared", int'(overrun), 0);
        pwm_in = 1'b1;
        tick(LAT + 255);
        check("to before", int'(timeout), 0);
        tick(1);
        check("to after", int'(timeout), 1);
        check("to valid", int'(meas.meas_valid), 0);

        // Abort mid-HIGH, then measure a clean 10/4 period
        got.delete();
        pwm_in = 1'b0;
        tick(LAT + 2);
        pwm_in = 1'b1;
        tick(LAT + 3);
        enable = 1'b0;
        pwm_in = 1'b0;
        tick(LAT + 4);
        check("abort timeout sticky", int'(timeout), 1);
        enable = 1'b1;
        tick(2);
        check("reen timeout", int'(timeout), 0);
        pwm_period(4, 6);
        pwm_in = 1'b1;
        tick(LAT + 4);
        check("abort count", got.size(), 1);
        if (got.size() > 0) begin
            check("abort period", got[0].per, 10);
            check("abort high_time", got[0].hi, 4);
        end
        check("abort overrun", int'(overrun), 0);

        // Asynchronous reset while a result is held and the FSM is in LOW
        meas.meas_ready = 1'b0;
        pwm_in = 1'b0;
        tick(4);
        pwm_in = 1'b1;
        tick(5);
        pwm_in = 1'b0;
        tick(LAT + 2);
        check("pre-rst valid", int'(meas.meas_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst valid", int'(meas.meas_valid), 0);
        check("arst period", int'(meas.period), 0);
        check("arst high_time", int'(meas.high_time), 0);
        check("arst overrun", int'(overrun), 0);
        check("arst timeout", int'(timeout), 0);
        @(negedge clk);
        rst = 1'b0;
        tick(4);
        check("post-rst valid", int'(meas.meas_valid), 0);

        // 2-cycle glitch inside a 20/10 waveform
        meas.meas_ready = 1'b1;
        restart();
        pwm_period(10, 10);
        pwm_in = 1'b1;
        tick(4);
        pwm_in = 1'b0;
        tick(2);
        pwm_in = 1'b1;
        tick(4);
        pwm_in = 1'b0;
        tick(10);
        pwm_period(10, 10);
        pwm_in = 1'b1;
        tick(LAT + 4);
        check("glitch count", got.size(), exp_q.size());
        for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
            check($sformatf("glitch[%0d] period", k), got[k].per, exp_q[k].per);
            check($sformatf("glitch[%0d] high_time", k), got[k].hi, exp_q[k].hi);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
